pc_target_table: RTL
====================

# pc_target_table

Runtime-programmable branch-target table for the processor's fetch stage. Maps a small jump index from the instruction to a full PC target, generalised to a parametrised width, depth and number of program banks, each loadable after reset. Adds a registered lookup with valid/miss flags, a bank-select register and a sequenced bank-clear engine. Sits between decode (index source) and the PC update mux.

## Interface
- D, 12, target/PC width in bits
- A, 4, index width; 2**A entries per bank
- NB, 2, number of program banks (NB ≥ 1); BW = max(1, $clog2(NB))
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- bank_sel  in  BW  bank to activate
- bank_switch  in  1  pulse: load bank_sel into the active-bank register
- lookup_req  in  1  lookup strobe
- lookup_idx  in  A  entry index
- target  out  D  looked-up target
- target_valid  out  1  one-cycle strobe with target
- miss  out  1  qualifies target_valid: entry unprogrammed
- wr_en  in  1  entry write strobe
- wr_bank  in  BW  write bank
- wr_idx  in  A  write index
- wr_data  in  D  write value
- wr_ready  out  1  writes accepted this cycle
- clr_req  in  1  request clearing of one bank
- clr_bank  in  BW  bank to clear
- busy  out  1  clear engine active

## Operation
- Storage: NB × 2**A entries of D bits, each with a valid bit.
- Reset (async): all valid bits 0; active bank 0; FSM IDLE; target=0, target_valid=0, miss=0, busy=0, wr_ready=1. Data contents need not be reset.
- Lookup: reads active bank at lookup_idx. Valid entry → target=data, miss=0. Invalid entry → target=0 (hold PC), miss=1.
- target holds its last value when target_valid=0.
- Write: accepted when wr_en && wr_ready. Stores wr_data and sets the valid bit. wr_bank ≥ NB is ignored.
- Write/lookup same cycle, same bank and index: the lookup returns the new wr_data with miss=0 (forwarded).
- bank_switch: the active bank updates at the edge. A lookup in the same cycle uses the old bank. bank_sel ≥ NB is ignored.
- FSM states:
  - IDLE: wr_ready=1, busy=0. clr_req with a valid clr_bank → CLEAR, counter=0, latch clr_bank. clr_bank ≥ NB is ignored.
  - CLEAR: busy=1, wr_ready=0. Clears one valid bit per cycle (counter 0 … 2**A−1). After the last index → IDLE.
- A CLEAR takes exactly 2**A cycles. clr_req is ignored while busy.
- Lookups to the bank being cleared during CLEAR report miss=1 for every index, including indices not yet cleared. Lookups to other banks are unaffected.
- Reset mid-CLEAR: immediate IDLE; all valid bits 0.

## Timing
- Lookup latency 1: lookup_req at edge N → target/target_valid/miss valid after edge N+1, for one cycle.
- Back-to-back lookups are supported every cycle.
- Write is visible to a lookup in the same cycle (forward) and in all later cycles.
- clr_req at edge N → busy=1 from N+1 through N+2**A. wr_ready returns to 1 at N+2**A+1.
- bank_switch at edge N → lookups from N+1 use the new bank.

## Configuration
- PC_TABLE_RELATIVE_EN defined:
  - Adds input pc [D-1:0], sampled with lookup_req.
  - Entries hold two's-complement offsets.
  - target = (pc + data) mod 2**D.
  - A miss still returns target=0, with miss=1.
- Undefined: entries are absolute targets; no pc port.

## Structure
- Package pc_table_pkg: FSM state enum (IDLE, CLEAR), BW derivation function, default D/A/NB constants.
- Sub-module pc_table_mem: data array and valid-bit array, with one write port, one combinational read port and a single-bit valid-clear port. Top level holds the active bank register, FSM/counter, forwarding and output registers.

## Test plan
- Reset, then lookup idx 3 → target=0, miss=1, target_valid=1 one cycle after the request.
- Write bank0 idx0=53, idx7=400 → lookups return 53 then 400, miss=0, on back-to-back cycles.
- Write bank1 idx0=159 with bank0 idx0=53, bank_switch to 1 in the same cycle as a lookup idx0 → returns 53; the next lookup returns 159.
- Write idx5=138 and lookup idx5 in the same cycle → target=138, miss=0.
- clr_req bank0 (A=4) → busy exactly 16 cycles; a write during busy is dropped; lookups of bank0 miss, bank1 hit. Assert Reset mid-clear → all entries miss and wr_ready=1.
- With PC_TABLE_RELATIVE_EN: entry=−5 (0xFFB), pc=4 → target=0xFFF. Entry=+20, pc=0xFFF → target=0x013 (wrap).

Source files
------------

// File: rtl/pc_table_pkg.sv
// Shared types and constants for the branch-target table.
// Optional build macro: PC_TABLE_RELATIVE_EN (entries hold offsets that are added to pc).
package pc_table_pkg;

  localparam int DEF_D  = 12;
  localparam int DEF_A  = 4;
  localparam int DEF_NB = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // A bank select is always at least one bit wide, even for a single bank.
  function automatic int bw_of(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/pc_table_mem.sv
// Banked target storage: data RAM plus per-entry valid flags.
// Holds no configuration of its own; PC_TABLE_RELATIVE_EN only affects the top level.
module pc_table_mem
  import pc_table_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int A  = DEF_A,
  parameter int NB = DEF_NB,
  localparam int BW = bw_of(NB)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_bank,
  input  logic [A-1:0]  wr_idx,
  input  logic [D-1:0]  wr_data,
  input  logic [BW-1:0] rd_bank,
  input  logic [A-1:0]  rd_idx,
  output logic [D-1:0]  rd_data,
  output logic          rd_valid,
  input  logic          clr_en,
  input  logic [BW-1:0] clr_bank,
  input  logic [A-1:0]  clr_idx
);

  localparam int ENTRIES = 2 ** A;
  localparam int DEPTH   = NB * ENTRIES;
  localparam int AW      = BW + A;

  logic [D-1:0]     data_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] clr_addr;

  assign wr_addr  = {wr_bank, wr_idx};
  assign rd_addr  = {rd_bank, rd_idx};
  assign clr_addr = {clr_bank, clr_idx};

  // Data contents are never reset; the valid flags alone decide hit/miss.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      data_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = data_mem[rd_addr];
  assign rd_valid = valid_reg[rd_addr];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (clr_en && (clr_addr == AW'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pc_target_table.sv
// Runtime-programmable branch-target table with registered lookup and bank clear engine.
// Define PC_TABLE_RELATIVE_EN to treat entries as offsets added to the sampled pc.
module pc_target_table
  import pc_table_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int A  = DEF_A,
  parameter int NB = DEF_NB,
  localparam int BW = bw_of(NB)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [BW-1:0] bank_sel,
  input  logic          bank_switch,
  input  logic          lookup_req,
  input  logic [A-1:0]  lookup_idx,
`ifdef PC_TABLE_RELATIVE_EN
  input  logic [D-1:0]  pc,
`endif
  output logic [D-1:0]  target,
  output logic          target_valid,
  output logic          miss,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_bank,
  input  logic [A-1:0]  wr_idx,
  input  logic [D-1:0]  wr_data,
  output logic          wr_ready,
  input  logic          clr_req,
  input  logic [BW-1:0] clr_bank,
  output logic          busy
);

  localparam logic [BW:0]  NB_L     = (BW + 1)'(NB);
  localparam logic [A-1:0] LAST_IDX = '1;

  function automatic logic bank_ok(input logic [BW-1:0] b);
    return ({1'b0, b} < NB_L);
  endfunction

  state_t        state_reg;
  logic [A-1:0]  cnt_reg;
  logic [BW-1:0] clr_bank_reg;
  logic [BW-1:0] active_bank_reg;

  logic [D-1:0]  target_reg;
  logic          target_valid_reg;
  logic          miss_reg;

  logic          wr_accept;
  logic [D-1:0]  rd_data;
  logic          rd_valid;
  logic          fwd_hit;
  logic          clr_block;
  logic          hit_next;
  logic [D-1:0]  data_next;
  logic [D-1:0]  target_next;

  assign busy     = (state_reg == ST_CLEAR);
  assign wr_ready = (state_reg == ST_IDLE);

  assign wr_accept = wr_en && wr_ready && bank_ok(wr_bank);

  pc_table_mem #(
    .D  (D),
    .A  (A),
    .NB (NB)
  ) u_mem (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_en    (wr_accept),
    .wr_bank  (wr_bank),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd_bank  (active_bank_reg),
    .rd_idx   (lookup_idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .clr_en   (busy),
    .clr_bank (clr_bank_reg),
    .clr_idx  (cnt_reg)
  );

  // A write landing on the looked-up entry this cycle wins over the stored copy.
  assign fwd_hit   = wr_accept && (wr_bank == active_bank_reg) && (wr_idx == lookup_idx);
  // The whole bank under clear reads as empty, even entries the counter has not reached.
  assign clr_block = busy && (clr_bank_reg == active_bank_reg);

  always_comb begin
    hit_next  = 1'b0;
    data_next = rd_data;
    if (fwd_hit) begin
      hit_next  = 1'b1;
      data_next = wr_data;
    end else if (!clr_block && rd_valid) begin
      hit_next = 1'b1;
    end
  end

  always_comb begin
    target_next = '0;
    if (hit_next) begin
`ifdef PC_TABLE_RELATIVE_EN
      target_next = pc + data_next;
`else
      target_next = data_next;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      target_reg       <= '0;
      target_valid_reg <= 1'b0;
      miss_reg         <= 1'b0;
    end else begin
      target_valid_reg <= lookup_req;
      miss_reg         <= lookup_req && !hit_next;
      if (lookup_req) begin
        target_reg <= target_next;
      end
    end
  end

  assign target       = target_reg;
  assign target_valid = target_valid_reg;
  assign miss         = miss_reg;

  // Same-cycle lookups still see the old bank because the read uses the register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active_bank_reg <= '0;
    end else if (bank_switch && bank_ok(bank_sel)) begin
      active_bank_reg <= bank_sel;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      clr_bank_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clr_req && bank_ok(clr_bank)) begin
            state_reg    <= ST_CLEAR;
            cnt_reg      <= '0;
            clr_bank_reg <= clr_bank;
          end
        end
        ST_CLEAR: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
